// File: rtl/bidir_host_pkg.sv
// bidir_host_pkg: state encoding and link defaults shared by the host and the echo stage
package bidir_host_pkg;
  typedef enum logic [2:0] {IDLE, STROBE, SEND, TURN, RECV} state_t;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_WAIT_CYCLES = 32;
endpackage

// File: rtl/bidir_host_pad.sv
// bidir_host_pad: tristate pad for the shared single-wire line
module bidir_host_pad (
  input  logic out,
  input  logic oe,
  inout  wire  io,
  output logic in
);
  assign io = oe ? out : 1'bz;
  assign in = io;
endmodule

// File: rtl/bidir_host.sv
// bidir_host: sends a byte MSB-first on a shared line, waits out the echo turnaround, checks the returned byte
module bidir_host
  import bidir_host_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter int CNT_WIDTH = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_stb,
  inout  wire                   io_data,
  output logic                  o_rx_valid,
  output logic [DATA_WIDTH-1:0] o_rx_data,
  output logic                  o_match,
  output logic [CNT_WIDTH-1:0]  o_mismatch_cnt
);
  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam int WW = $clog2(WAIT_CYCLES + 1);
  state_t state, state_nx;
  logic [DATA_WIDTH-1:0] tx_sr, tx_ref, rx_sr, rx_word;
  logic [BW-1:0] bit_cnt;
  logic [WW-1:0] wait_cnt;
  logic oe, out, line_in, accept, send_done, turn_done, recv_done, miss;
  bidir_host_pad pad (.out(out), .oe(oe), .io(io_data), .in(line_in));
  assign o_ready = state == IDLE;
  assign o_stb = state == STROBE;
  assign accept = i_valid && o_ready;
  assign send_done = bit_cnt == '0;
  assign turn_done = wait_cnt == WW'(WAIT_CYCLES - 1);
  assign recv_done = bit_cnt == BW'(1);
  assign rx_word = {rx_sr[DATA_WIDTH-2:0], line_in};
  assign miss = rx_word != tx_ref;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = accept ? STROBE : IDLE;
      STROBE:  state_nx = SEND;
      SEND:    state_nx = send_done ? TURN : SEND;
      TURN:    state_nx = turn_done ? RECV : TURN;
      RECV:    state_nx = recv_done ? IDLE : RECV;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      tx_sr <= '0;
      tx_ref <= '0;
      rx_sr <= '0;
      bit_cnt <= '0;
      wait_cnt <= '0;
      oe <= 1'b0;
      out <= 1'b0;
      o_rx_valid <= 1'b0;
      o_rx_data <= '0;
      o_match <= 1'b0;
      o_mismatch_cnt <= '0;
    end else begin
      o_rx_valid <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          tx_sr <= i_data;
          tx_ref <= i_data;
        end
        STROBE: begin
          oe <= 1'b1;
          out <= tx_sr[DATA_WIDTH-1];
          tx_sr <= tx_sr << 1;
          bit_cnt <= BW'(DATA_WIDTH - 1);
        end
        SEND: if (send_done) begin
          oe <= 1'b0;
          wait_cnt <= '0;
        end else begin
          out <= tx_sr[DATA_WIDTH-1];
          tx_sr <= tx_sr << 1;
          bit_cnt <= bit_cnt - BW'(1);
        end
        TURN: begin
          wait_cnt <= wait_cnt + WW'(1);
          if (turn_done) bit_cnt <= BW'(DATA_WIDTH);
        end
        RECV: begin
          rx_sr <= rx_word;
          bit_cnt <= bit_cnt - BW'(1);
          if (recv_done) begin
            o_rx_data <= rx_word;
            o_rx_valid <= 1'b1;
            o_match <= !miss;
            if (miss && !(&o_mismatch_cnt)) o_mismatch_cnt <= o_mismatch_cnt + CNT_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
endmodule

// File: doc/bidir_host.md
Name: bidir_host

Overview:
- Host-side master for the single-wire bidirectional echo link; sits directly upstream of the echo stage.
- Accepts a byte via valid/ready, pulses a one-cycle strobe, and shifts the byte MSB-first onto the shared line.
- Then releases the line, waits out the echo stage's turnaround, and samples the returned byte.
- Reports the received byte, a match flag against the sent byte, and a saturating mismatch count.

Parameters:
- DATA_WIDTH, 8, bits per transfer; must equal the echo stage's read count.
- WAIT_CYCLES, 32, echo stage idle cycles between its last sample and its first driven bit.
- CNT_WIDTH, 16, width of the mismatch counter.

Ports:
- i_clk  input  1  system clock; shared with the echo stage.
- i_rst_n  input  1  asynchronous active-low reset.
- i_valid  input  1  transmit byte valid.
- o_ready  output  1  host idle; can accept a byte.
- i_data  input  DATA_WIDTH  byte to send.
- o_stb  output  1  one-cycle start strobe to the echo stage.
- io_data  inout  1  shared data line; driven only while the output enable is set, else high-Z.
- o_rx_valid  output  1  one-cycle pulse when o_rx_data is updated.
- o_rx_data  output  DATA_WIDTH  returned byte.
- o_match  output  1  o_rx_data equals the byte sent; valid with o_rx_valid.
- o_mismatch_cnt  output  CNT_WIDTH  saturating count of mismatched transfers.

Behaviour:
- Reset, asynchronous, takes effect immediately even mid-transfer:
  - state IDLE; o_ready=1; o_stb=0; output enable=0 (line released at once).
  - o_rx_valid=0, o_rx_data=0, o_match=0, o_mismatch_cnt=0; all shift registers and counters cleared.
- Handshake:
  - A transfer is accepted at edge S when i_valid && o_ready.
  - i_data is captured into tx_sr and a copy kept in tx_ref.
  - o_ready is high only in IDLE; i_valid outside IDLE is ignored.
- States:
  - IDLE: on accept -> STROBE; o_stb<=1, o_ready<=0.
  - STROBE (edge S+1): o_stb<=0; oe<=1; out<=tx_sr[MSB]; shift tx_sr; bit_cnt<=DATA_WIDTH-1 -> SEND.
  - SEND: each edge drives the next bit (edges S+2..S+DATA_WIDTH). The bit for the final edge is already on the line; at edge S+DATA_WIDTH+1 set oe<=0, wait_cnt<=0 -> TURN.
  - TURN: counts WAIT_CYCLES edges (S+10..S+41 at defaults). On the last, bit_cnt<=DATA_WIDTH -> RECV.
  - RECV: samples io_data each edge into rx_sr MSB-first: S+WAIT_CYCLES+10 .. S+WAIT_CYCLES+9+DATA_WIDTH (S+42..S+49 at defaults).
  - RECV final sample edge, all in the same edge:
    - o_rx_data<={rx_sr[DATA_WIDTH-2:0], io_data}; o_rx_valid<=1; o_match<=(that value == tx_ref).
    - On mismatch, o_mismatch_cnt increments, saturating at all-ones.
    - o_ready<=1 -> IDLE.
- o_rx_valid deasserts on the following edge. o_rx_data and o_match hold until the next completion.
- At defaults, back-to-back accept is possible at S+50; the echo stage is back in its idle state by then.
- Line ownership:
  - Host drives only during edges S+1..S+DATA_WIDTH+1, then releases.
  - The echo stage drives from its edge S+WAIT_CYCLES+9 to S+WAIT_CYCLES+9+DATA_WIDTH.
  - Contention is never allowed.
- Widths: bit_cnt and wait_cnt are sized with $clog2 of DATA_WIDTH+1 and WAIT_CYCLES+1 respectively; no wrap occurs in normal operation.
- o_mismatch_cnt never wraps.

Decomposition:
- Shared package: state encoding constants (IDLE, STROBE, SEND, TURN, RECV) and default DATA_WIDTH / WAIT_CYCLES, shared with the echo stage so both ends agree.
- Optional sub-module bidir_pad: tristate buffer (out, oe -> io, in). All sequential logic stays in bidir_host.

Test Plan:
- Host loopback with the echo stage, send 0xA5 -> o_rx_valid pulses at edge S+49 with o_rx_data=0xA5, o_match=1, o_mismatch_cnt=0.
- Send 0x01, then 0x80 back-to-back (second i_valid held high) -> second accept at S+50; both return correctly; line driven only in the specified windows (X/contention checker on io_data).
- Bench model of the echo stage returns 0x5A for sent 0xA5 -> o_match=0, o_mismatch_cnt=1. Repeat with the counter preloaded near all-ones -> saturates at 0xFFFF.
- Assert i_rst_n low at edge S+5 (mid-SEND) -> io_data is high-Z in the same cycle; o_ready=1, o_stb=0, no o_rx_valid. A new transfer after reset completes normally.
- i_valid pulsed during TURN -> ignored; o_ready stays 0; no second o_stb.
- Send 0x00 and 0xFF -> returned exactly; o_stb high for exactly one cycle per transfer.
